debug_frame_printer: RTL and testbench
======================================

# debug_frame_printer

Parametrised UART debug framer sitting between control logic and the UART TX port of `debug_port`. On a trigger strobe it snapshots a bus of `NUM_WORDS` words of `WORD_W` bits each. It then emits one framed message: LF, start marker, payload, end marker, LF. Transmission uses a proper valid/ready handshake, and the payload is encoded as raw bytes or, optionally, ASCII hex. Triggers that arrive while a frame is in flight are dropped and counted.

## Interface
Parameters:
- `NUM_WORDS`, 2: number of payload words per frame (1..16).
- `WORD_W`, 16: payload word width in bits; must be a multiple of 8 (8..64).
- `START_BYTE`, 8'h24: marker byte sent after the leading LF.
- `END_BYTE`, 8'h24: marker byte sent before the trailing LF.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_trig`  in  1  single-cycle frame request strobe.
- `i_words`  in  NUM_WORDS*WORD_W  payload; word k is `i_words[k*WORD_W +: WORD_W]`.
- `o_busy`  out  1  frame in progress.
- `o_drop_cnt`  out  8  count of dropped triggers, saturating.
- `o_wdata`  out  8  byte to UART TX.
- `o_wvalid`  out  1  `o_wdata` valid.
- `i_wready`  in  1  UART TX can accept a byte.

## Operation
- States: IDLE, LEAD, START, DATA, END, TAIL.
  - LEAD emits 8'h0A.
  - START emits `START_BYTE`.
  - DATA emits the payload.
  - END emits `END_BYTE`.
  - TAIL emits 8'h0A.
- IDLE + `i_trig`=1:
  - Latch all of `i_words` into an internal snapshot register.
  - Enter LEAD.
  - Subsequent changes on `i_words` do not affect the frame.
- A state advances only on a transfer, i.e. `o_wvalid`=1 and `i_wready`=1 in the same cycle. Transfer in TAIL returns to IDLE.
- DATA order: word 0 first, each word most-significant byte first.
  - Raw mode sends `NUM_WORDS*WORD_W/8` bytes.
  - A byte/nibble index counter of width clog2(payload units) tracks position and wraps to 0 on leaving DATA.
- Frame length (raw) = 4 + NUM_WORDS*WORD_W/8 bytes.
- `i_trig` while `o_busy`=1: the trigger is ignored and the frame is unaffected. `o_drop_cnt` increments by 1, saturating at 8'hFF with no wrap.
- `i_trig` in the cycle of the final TAIL transfer is dropped, because `o_busy` is still 1.
- Asynchronous reset mid-frame aborts immediately: the FSM goes to IDLE and the snapshot is discarded.

## Timing
- Reset values: `o_busy`=0, `o_wvalid`=0, `o_wdata`=8'h00, `o_drop_cnt`=0, state IDLE, counters 0.
- Latency: `i_trig` sampled at edge t gives `o_wvalid`=1 with `o_wdata`=8'h0A and `o_busy`=1 from edge t onward, i.e. the next cycle.
- All outputs are registered; there is no combinational path from `i_wready` or `i_trig` to outputs.
- Hold rule: while `o_wvalid`=1 and `i_wready`=0, `o_wdata` and the state are held unchanged.
- `o_wvalid` never deasserts without a transfer, except on reset.
- Throughput: with `i_wready` held at 1, one byte per cycle, and `o_wvalid` is continuous for the whole frame.
- The edge after the TAIL transfer sets `o_wvalid`=0 and `o_busy`=0. The next trigger is accepted on the following cycle at the earliest.
- Minimum gap between frames: 1 idle cycle.

## Configuration
- `DBG_PRINT_HEX_EN` defined:
  - DATA emits each payload nibble, most-significant first, as uppercase ASCII hex: 0-9 map to 8'h30-8'h39, A-F map to 8'h41-8'h46.
  - Payload length is `NUM_WORDS*WORD_W/4` bytes.
  - Frame length = 4 + NUM_WORDS*WORD_W/4 bytes.
- `DBG_PRINT_HEX_EN` undefined: DATA emits raw payload bytes. Hex encoding logic is not synthesised.
- Markers and LF bytes are sent verbatim in both modes.

## Test plan
- Raw mode, defaults, `i_words`={16'h5678,16'h1234}, `i_wready`=1, single `i_trig` -> 8 consecutive transfers 0A 24 12 34 56 78 24 0A. Then `o_busy`=0 one cycle after the last transfer.
- Hex mode, same stimulus -> 12 transfers 0A 24 31 32 33 34 35 36 37 38 24 0A.
- Backpressure: toggle `i_wready` pseudo-randomly (50%) -> identical byte sequence, `o_wdata` stable whenever valid && !ready, no duplicate or lost byte. Change `i_words` mid-frame -> the frame still carries the latched values.
- Drop handling:
  - 3 triggers during a frame -> `o_drop_cnt`=3 and only one frame is emitted.
  - A trigger in the final-transfer cycle is also dropped.
  - 300 triggers while busy (`i_wready`=0) -> `o_drop_cnt`=8'hFF.
- Reset mid-frame: assert `i_rst`=0 after the 3rd transfer -> `o_wvalid`/`o_busy` go 0 asynchronously and `o_drop_cnt`=0. A trigger after release yields a complete fresh frame starting with 0A.
- Parametrisation: `NUM_WORDS`=3, `WORD_W`=32, raw mode, words 32'h0000_00FF, 32'hDEAD_BEEF, 32'h0102_0304 -> 16 bytes: 0A 24 00 00 00 FF DE AD BE EF 01 02 03 04 24 0A.

Source files
------------

// File: rtl/debug_frame_printer.sv
// debug_frame_printer: on a trigger, snapshots a word bus and streams LF, start marker, payload, end marker, LF
// over a valid/ready byte port. Optional macro DBG_PRINT_HEX_EN sends the payload as uppercase ASCII hex nibbles.
module debug_frame_printer #(
  parameter int unsigned NUM_WORDS  = 32'd2,
  parameter int unsigned WORD_W     = 32'd16,
  parameter logic [7:0]  START_BYTE = 8'h24,
  parameter logic [7:0]  END_BYTE   = 8'h24
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_trig,
  input  logic [NUM_WORDS*WORD_W-1:0] i_words,
  output logic                        o_busy,
  output logic [7:0]                  o_drop_cnt,
  output logic [7:0]                  o_wdata,
  output logic                        o_wvalid,
  input  logic                        i_wready
);

  localparam int unsigned PAY_W = NUM_WORDS * WORD_W;
`ifdef DBG_PRINT_HEX_EN
  localparam int unsigned UNIT_W = 32'd4;
`else
  localparam int unsigned UNIT_W = 32'd8;
`endif
  localparam int unsigned UNITS = PAY_W / UNIT_W;
  localparam int unsigned IDX_W = (UNITS > 32'd1) ? $clog2(UNITS) : 32'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UNITS - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [7:0] LF_BYTE = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_END   = 3'd4,
    ST_TAIL  = 3'd5
  } state_t;

  // Word 0 lands at the top so the payload leaves MSB-first by shifting left.
  function automatic logic [PAY_W-1:0] pack_stream(input logic [PAY_W-1:0] words);
    logic [PAY_W-1:0] stream;
    stream = {PAY_W{1'b0}};
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      stream[PAY_W-1-k*WORD_W -: WORD_W] = words[k*WORD_W +: WORD_W];
    end
    return stream;
  endfunction

`ifdef DBG_PRINT_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction
`endif

  state_t            state_r, state_s;
  logic [PAY_W-1:0]  stream_r, stream_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [7:0]        wdata_r, wdata_s;
  logic              wvalid_r, wvalid_s;
  logic              busy_r;
  logic [7:0]        drop_cnt_r, drop_cnt_s;
  logic              xfer_s;

  assign xfer_s = wvalid_r & i_wready;

  // Next-state: advance only on a transfer; the payload stream shifts one unit per DATA transfer.
  always_comb begin
    state_s  = state_r;
    stream_s = stream_r;
    idx_s    = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (i_trig) begin
          stream_s = pack_stream(i_words);
          state_s  = ST_LEAD;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (xfer_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_LEAD;
        end
      end
      ST_START: begin
        if (xfer_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = ST_END;
          end else begin
            idx_s    = idx_r + IDX_ONE;
            stream_s = stream_r << UNIT_W;
            state_s  = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_END: begin
        if (xfer_s) begin
          state_s = ST_TAIL;
        end else begin
          state_s = ST_END;
        end
      end
      ST_TAIL: begin
        if (xfer_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_TAIL;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Output byte is decoded from the upcoming state so o_wdata/o_wvalid stay purely registered.
  always_comb begin
    wvalid_s = 1'b1;
    wdata_s  = 8'h00;
    case (state_s)
      ST_IDLE: begin
        wvalid_s = 1'b0;
        wdata_s  = 8'h00;
      end
      ST_LEAD:  wdata_s = LF_BYTE;
      ST_START: wdata_s = START_BYTE;
`ifdef DBG_PRINT_HEX_EN
      ST_DATA:  wdata_s = hex_ascii(stream_s[PAY_W-1 -: 4]);
`else
      ST_DATA:  wdata_s = stream_s[PAY_W-1 -: 8];
`endif
      ST_END:   wdata_s = END_BYTE;
      ST_TAIL:  wdata_s = LF_BYTE;
      default: begin
        wvalid_s = 1'b0;
        wdata_s  = 8'h00;
      end
    endcase
  end

  // Saturating count of triggers that arrive while a frame is still owed a transfer.
  always_comb begin
    if (i_trig && busy_r && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_s = drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  // State and output registers; reset aborts any frame and discards the snapshot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      stream_r   <= {PAY_W{1'b0}};
      idx_r      <= IDX_ZERO;
      wdata_r    <= 8'h00;
      wvalid_r   <= 1'b0;
      busy_r     <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      state_r    <= state_s;
      stream_r   <= stream_s;
      idx_r      <= idx_s;
      wdata_r    <= wdata_s;
      wvalid_r   <= wvalid_s;
      busy_r     <= wvalid_s;
      drop_cnt_r <= drop_cnt_s;
    end
  end

  assign o_busy     = busy_r;
  assign o_wvalid   = wvalid_r;
  assign o_wdata    = wdata_r;
  assign o_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_debug_frame_printer.sv
// Self-checking bench for debug_frame_printer: a byte-queue frame model compared every cycle,
// plus literal frame/counter expectations. Two instances: defaults and NUM_WORDS=3/WORD_W=32.
module tb_debug_frame_printer;

  localparam int NW_A = 2;
  localparam int WW_A = 16;
  localparam int NW_B = 3;
  localparam int WW_B = 32;

`ifdef DBG_PRINT_HEX_EN
  localparam int LEN_A = 12;
  localparam int LEN_B = 28;
  localparam logic [7:0] LIT_A [LEN_A] = '{8'h0A, 8'h24, 8'h31, 8'h32, 8'h33, 8'h34,
                                           8'h35, 8'h36, 8'h37, 8'h38, 8'h24, 8'h0A};
  localparam logic [7:0] LIT_B [LEN_B] = '{8'h0A, 8'h24,
                                           8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h46,
                                           8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46,
                                           8'h30, 8'h31, 8'h30, 8'h32, 8'h30, 8'h33, 8'h30, 8'h34,
                                           8'h24, 8'h0A};
`else
  localparam int LEN_A = 8;
  localparam int LEN_B = 16;
  localparam logic [7:0] LIT_A [LEN_A] = '{8'h0A, 8'h24, 8'h12, 8'h34, 8'h56, 8'h78, 8'h24, 8'h0A};
  localparam logic [7:0] LIT_B [LEN_B] = '{8'h0A, 8'h24, 8'h00, 8'h00, 8'h00, 8'hFF,
                                           8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
                                           8'h24, 8'h0A};
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic trig_a, wready_a, o_busy_a, o_wvalid_a;
  logic [NW_A*WW_A-1:0] words_a;
  logic [7:0] o_drop_a, o_wdata_a;
  logic trig_b, wready_b, o_busy_b, o_wvalid_b;
  logic [NW_B*WW_B-1:0] words_b;
  logic [7:0] o_drop_b, o_wdata_b;

  always #5 clk = ~clk;

  debug_frame_printer u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_trig(trig_a), .i_words(words_a),
    .o_busy(o_busy_a), .o_drop_cnt(o_drop_a), .o_wdata(o_wdata_a),
    .o_wvalid(o_wvalid_a), .i_wready(wready_a)
  );

  debug_frame_printer #(.NUM_WORDS(NW_B), .WORD_W(WW_B)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_trig(trig_b), .i_words(words_b),
    .o_busy(o_busy_b), .o_drop_cnt(o_drop_b), .o_wdata(o_wdata_b),
    .o_wvalid(o_wvalid_b), .i_wready(wready_b)
  );

  // Model: pending frame bytes per instance, busy flag and drop counter.
  logic [7:0] exp_a[$], exp_b[$], log_a[$], log_b[$];
  logic       m_busy_a, m_busy_b;
  logic [7:0] m_drop_a, m_drop_b;
  int errors = 0;
  int checks = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h required %02h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else return 8'h41 + ({4'd0, n} - 8'd10);
  endfunction

  task automatic build_frame(input int which, input logic [127:0] w, input int nw, input int ww);
    logic [7:0] fr[$];
    logic [7:0] b;
    fr.push_back(8'h0A);
    fr.push_back(8'h24);
    for (int k = 0; k < nw; k++) begin
      for (int i = ww - 8; i >= 0; i -= 8) begin
        b = w[k*ww + i +: 8];
`ifdef DBG_PRINT_HEX_EN
        fr.push_back(asc(b[7:4]));
        fr.push_back(asc(b[3:0]));
`else
        fr.push_back(b);
`endif
      end
    end
    fr.push_back(8'h24);
    fr.push_back(8'h0A);
    if (which == 0) exp_a = fr;
    else exp_b = fr;
  endtask

  task automatic model_clear();
    exp_a.delete(); exp_b.delete();
    m_busy_a = 1'b0; m_busy_b = 1'b0;
    m_drop_a = 8'h00; m_drop_b = 8'h00;
  endtask

  // Advance the model with the inputs about to be sampled by the next rising edge.
  task automatic model_step();
    logic was_busy;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (o_wvalid_a && wready_a) log_a.push_back(o_wdata_a);
    if (o_wvalid_b && wready_b) log_b.push_back(o_wdata_b);
    was_busy = m_busy_a;
    if (m_busy_a && wready_a) begin
      exp_a.delete(0);
      if (exp_a.size() == 0) m_busy_a = 1'b0;
    end
    if (trig_a) begin
      if (was_busy) begin
        if (m_drop_a != 8'hFF) m_drop_a = m_drop_a + 8'd1;
      end else begin
        build_frame(0, {96'd0, words_a}, NW_A, WW_A);
        m_busy_a = 1'b1;
      end
    end
    was_busy = m_busy_b;
    if (m_busy_b && wready_b) begin
      exp_b.delete(0);
      if (exp_b.size() == 0) m_busy_b = 1'b0;
    end
    if (trig_b) begin
      if (was_busy) begin
        if (m_drop_b != 8'hFF) m_drop_b = m_drop_b + 8'd1;
      end else begin
        build_frame(1, {32'd0, words_b}, NW_B, WW_B);
        m_busy_b = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check8("busy_a", {7'd0, o_busy_a}, {7'd0, m_busy_a});
    check8("wvalid_a", {7'd0, o_wvalid_a}, {7'd0, m_busy_a});
    check8("drop_a", o_drop_a, m_drop_a);
    if (m_busy_a) check8("wdata_a", o_wdata_a, exp_a[0]);
    check8("busy_b", {7'd0, o_busy_b}, {7'd0, m_busy_b});
    check8("wvalid_b", {7'd0, o_wvalid_b}, {7'd0, m_busy_b});
    check8("drop_b", o_drop_b, m_drop_b);
    if (m_busy_b) check8("wdata_b", o_wdata_b, exp_b[0]);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run_idle(input int which, input int budget, output int n);
    n = 0;
    while (((which == 0) ? m_busy_a : m_busy_b) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if ((which == 0) ? m_busy_a : m_busy_b) begin
      errors++;
      $display("FAIL timeout_%0d: still busy after %0d cycles, required idle", which, n);
    end
  endtask

  task automatic check_lit(input int which, input int start, input string name);
    int sz;
    sz = (which == 0) ? log_a.size() : log_b.size();
    check8({name, "_len"}, 8'(sz - start), 8'((which == 0) ? LEN_A : LEN_B));
    for (int i = 0; i < ((which == 0) ? LEN_A : LEN_B); i++) begin
      if (start + i < sz) begin
        if (which == 0) check8(name, log_a[start+i], LIT_A[i]);
        else check8(name, log_b[start+i], LIT_B[i]);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig_a = 1'b0;
    trig_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int s, n;
    rst_n = 1'b0;
    trig_a = 1'b0; wready_a = 1'b0; words_a = '0;
    trig_b = 1'b0; wready_b = 1'b0; words_b = '0;
    model_clear();
    do_reset();
    check8("rst_busy", {7'd0, o_busy_a}, 8'h00);
    check8("rst_wvalid", {7'd0, o_wvalid_a}, 8'h00);
    check8("rst_wdata", o_wdata_a, 8'h00);
    check8("rst_drop", o_drop_a, 8'h00);

    // Basic frame, then immediate retrigger after the one idle cycle.
    words_a = {16'h5678, 16'h1234};
    wready_a = 1'b1;
    s = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    check8("lat_valid", {7'd0, o_wvalid_a}, 8'h01);
    check8("lat_data", o_wdata_a, 8'h0A);
    run_idle(0, 60, n);
    check8("t1_cycles", 8'(n), 8'(LEN_A));
    check8("t1_idle", {7'd0, o_busy_a}, 8'h00);
    check_lit(0, s, "t1");
    s = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    check8("regap_busy", {7'd0, o_busy_a}, 8'h01);
    run_idle(0, 60, n);
    check_lit(0, s, "t1b");

    // Backpressure with the bus changing mid-frame.
    s = log_a.size();
    wready_a = 1'b0;
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    tick();
    for (int i = 0; i < 400 && m_busy_a; i++) begin
      wready_a = 1'($urandom_range(0, 1));
      if (i == 3) words_a = 32'hFFFF_0000;
      tick();
    end
    wready_a = 1'b1;
    run_idle(0, 60, n);
    check_lit(0, s, "t2");

    // Drops during a frame, including one on the final transfer.
    words_a = {16'h5678, 16'h1234};
    do_reset();
    s = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    tick();
    trig_a = 1'b1; tick(); tick(); tick(); trig_a = 1'b0;
    check8("drop3", o_drop_a, 8'd3);
    for (int i = 0; i < 60 && m_busy_a; i++) begin
      trig_a = (exp_a.size() == 1) ? 1'b1 : 1'b0;
      tick();
    end
    trig_a = 1'b0;
    tick(); tick();
    check8("drop_final", o_drop_a, 8'd4);
    check8("no_refrm", {7'd0, o_busy_a}, 8'h00);
    check_lit(0, s, "t3");

    // Saturation with the sink stalled.
    wready_a = 1'b0;
    s = log_a.size();
    trig_a = 1'b1;
    for (int i = 0; i < 301; i++) tick();
    trig_a = 1'b0;
    check8("drop_sat", o_drop_a, 8'hFF);
    wready_a = 1'b1;
    run_idle(0, 60, n);
    check_lit(0, s, "t4");

    // Asynchronous reset after the third transfer, then a fresh frame.
    s = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    tick(); tick(); tick();
    check8("pre_rst_xfers", 8'(log_a.size() - s), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    check8("arst_wvalid", {7'd0, o_wvalid_a}, 8'h00);
    check8("arst_busy", {7'd0, o_busy_a}, 8'h00);
    check8("arst_drop", o_drop_a, 8'h00);
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    s = log_a.size();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    check8("fresh_first", o_wdata_a, 8'h0A);
    run_idle(0, 60, n);
    check_lit(0, s, "t5");

    // Wider instance: three 32-bit words.
    words_b = {32'h0102_0304, 32'hDEAD_BEEF, 32'h0000_00FF};
    wready_b = 1'b1;
    s = log_b.size();
    trig_b = 1'b1; tick(); trig_b = 1'b0;
    run_idle(1, 80, n);
    check8("t6_cycles", 8'(n), 8'(LEN_B));
    check_lit(1, s, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
